// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the UART TX arbiter.
//   arb_state_t       : arbiter FSM states (IDLE, START, WAIT)
//   DATA_W            : byte width carried to the transmitter
//   UART_FRAME_CYCLES : nominal transmitter frame length, start to done
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int DATA_W            = 8;
  localparam int UART_FRAME_CYCLES = 12;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req   [N-1:0]  : request vector
//   last  [IW-1:0] : most recently granted index; the search starts at last+1
//   grant [N-1:0]  : one-hot winner (all zero when nothing is requested)
//   idx   [IW-1:0] : binary index of the winner
//   any            : at least one request bit is set
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand;

  // Walk offsets 1..N from the last winner; the last offset wraps back to
  // 'last' itself, so a lone requester can be granted repeatedly.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(last) + off) % N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8-bit UART transmitter between NUM_REQ byte
// producers with round-robin arbitration.
//
// Handshake: a requester holds req_valid[i] and its byte on req_data until
// it sees req_ready[i] high for one cycle; the byte is captured in that
// cycle and req_ready is never asserted for more than one requester at once.
//
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   req_valid / req_data    : per-requester valid and packed bytes
//   req_ready               : one-hot, one-cycle accept pulse
//   uart_tx_start           : one-cycle start pulse to the transmitter
//   uart_data               : byte held for the whole frame
//   uart_tx_done            : one-cycle done pulse from the transmitter
//   busy                    : FSM is not in IDLE
//   grant_id                : current or last granted requester
//   frame_cnt               : completed frames (wraps)
//   err_timeout             : watchdog pulse, only with the optional feature
//   state_dbg               : FSM state, for observation
//
// Optional feature: define UART_ARB_TIMEOUT_EN to abort a frame whose done
// pulse has not arrived within TIMEOUT_CYCLES WAIT cycles.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        uart_tx_start,
  output logic [DATA_W-1:0]           uart_data,
  input  logic                        uart_tx_done,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [CNT_W-1:0]            frame_cnt,
  output logic                        err_timeout,
  output arb_state_t                  state_dbg
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    grant_id_d;
  logic [DATA_W-1:0]   uart_data_d;
  logic [NUM_REQ-1:0]  req_ready_d;
  logic                uart_tx_start_d;
  logic                busy_d;
  logic [CNT_W-1:0]    frame_cnt_d;
  logic                err_timeout_d;

  logic [NUM_REQ-1:0]  win_onehot;
  logic [IDX_W-1:0]    win_idx;
  logic                win_any;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WAIT_W-1:0]   wait_q, wait_d;
`endif

  rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
    .req   (req_valid),
    .last  (last_q),
    .grant (win_onehot),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    grant_id_d      = grant_id;
    uart_data_d     = uart_data;
    req_ready_d     = '0;
    uart_tx_start_d = 1'b0;
    frame_cnt_d     = frame_cnt;
    err_timeout_d   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    wait_d          = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_any) begin
          uart_data_d = req_data[win_idx*DATA_W +: DATA_W];
          grant_id_d  = win_idx;
          last_d      = win_idx;
          req_ready_d = win_onehot;
          state_d     = START;
        end
      end
      START: begin
        uart_tx_start_d = 1'b1;
        state_d         = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
        wait_d          = '0;
`endif
      end
      WAIT: begin
        // Done wins over the watchdog when both land on the same cycle.
        if (uart_tx_done) begin
          frame_cnt_d = frame_cnt + CNT_W'(1);
          state_d     = IDLE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_q        <= IDX_W'(NUM_REQ - 1);
      grant_id      <= '0;
      uart_data     <= '0;
      req_ready     <= '0;
      uart_tx_start <= 1'b0;
      busy          <= 1'b0;
      frame_cnt     <= '0;
      err_timeout   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wait_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      grant_id      <= grant_id_d;
      uart_data     <= uart_data_d;
      req_ready     <= req_ready_d;
      uart_tx_start <= uart_tx_start_d;
      busy          <= busy_d;
      frame_cnt     <= frame_cnt_d;
      err_timeout   <= err_timeout_d;
`ifdef UART_ARB_TIMEOUT_EN
      wait_q        <= wait_d;
`endif
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter with a small
// transmitter model that answers each start pulse with a done pulse.
// Build with UART_ARB_TIMEOUT_EN defined to exercise the watchdog instead of
// the frame sequences.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 16;
  localparam int TX_LAT  = 10;  // negedges from seeing start to raising done
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_CYC  = 5;
`else
  localparam int TO_CYC  = 32;
`endif

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*8-1:0]      req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      uart_tx_start;
  logic [7:0]                uart_data;
  logic                      uart_tx_done;
  logic                      busy;
  logic [1:0]                grant_id;
  logic [CNT_W-1:0]          frame_cnt;
  logic                      err_timeout;
  arb_state_t                state_dbg;

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TO_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_tx_start(uart_tx_start), .uart_data(uart_data),
    .uart_tx_done(uart_tx_done), .busy(busy), .grant_id(grant_id),
    .frame_cnt(frame_cnt), .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  logic [1:0] gid_q[$];
  int vectors = 0;
  int errors  = 0;
  int exp_frames = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // transmitter model + output monitor
  logic       model_done = 1'b0;
  logic       spur_done  = 1'b0;
  bit         model_en   = 1'b1;
  bit         check_spacing = 1'b0;
  int         tx_cnt  = 0;
  int         acc_cnt = 0;
  int         last_acc = -1;
  logic [7:0] held = '0;
  logic [1:0] g;

  assign uart_tx_done = model_done | spur_done;

  always @(negedge clk) begin
    if (!reset_n) begin
      tx_cnt     = 0;
      model_done = 1'b0;
    end else begin
      if (req_ready != '0) begin
        acc_cnt++;
        if (gid_q.size() == 0) check("gid_sb_empty", 32'(req_ready), 32'd0);
        else begin
          g = gid_q.pop_front();
          check("req_ready", 32'(req_ready), 32'd1 << g);
          check("grant_id", 32'(grant_id), 32'(g));
        end
        if (check_spacing && last_acc >= 0) check("spacing", 32'(cyc - last_acc), 32'd13);
        last_acc = cyc;
      end
      model_done = 1'b0;
      if (uart_tx_start) begin
        if (exp_q.size() == 0) check("byte_sb_empty", 32'(uart_data), 32'hFFFF);
        else check("tx_byte", 32'(uart_data), 32'(exp_q.pop_front()));
        held   = uart_data;
        tx_cnt = TX_LAT;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0 && model_en) begin
          model_done = 1'b1;
          check("held_byte", 32'(uart_data), 32'(held));
          exp_frames++;
        end
      end
    end
  end

  // driver tasks
  task automatic wait_ready(input int idx);
    bit seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (req_ready[idx]) seen = 1'b1;
    end
    if (!seen) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input int idx, input logic [7:0] b);
    req_data[idx*8 +: 8] = b;
    req_valid[idx] = 1'b1;
    exp_q.push_back(b);
    gid_q.push_back(2'(idx));
    wait_ready(idx);
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    if (!seen) check("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
    check({pfx, "_tx_start"}, 32'(uart_tx_start), 32'd0);
    check({pfx, "_uart_data"}, 32'(uart_data), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_grant_id"}, 32'(grant_id), 32'd0);
    check({pfx, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({pfx, "_err_timeout"}, 32'(err_timeout), 32'd0);
    check({pfx, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    bit seen;
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

`ifndef UART_ARB_TIMEOUT_EN
    // all four requesters valid and held: round-robin 0,1,2,3,0, 13 apart
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h10 + 8'(i % 4));
      gid_q.push_back(2'(i % 4));
    end
    acc_cnt = 0;
    last_acc = -1;
    check_spacing = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 120 && acc_cnt < 5; i++) begin
      @(negedge clk);
      #1;
    end
    check("rr_accepts", 32'(acc_cnt), 32'd5);
    req_valid = '0;
    check_spacing = 1'b0;
    wait_idle();
    check("rr_frames", 32'(frame_cnt), 32'(exp_frames));

    // single request on requester 2
    send(2, 8'hA5);
    wait_idle();
    check("single_frames", 32'(frame_cnt), 32'(exp_frames));
    check("single_gid", 32'(grant_id), 32'd2);

    // byte changes after accept must not reach the frame
    send(0, 8'h5A);
    repeat (3) @(negedge clk);
    req_data[7:0] = 8'hFF;
    wait_idle();
    check("byte_kept_idle", 32'(uart_data), 32'h5A);

    // spurious done in IDLE
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    check("spur_state", 32'(state_dbg), 32'(IDLE));
    check("spur_busy", 32'(busy), 32'd0);
    check("spur_frames", 32'(frame_cnt), 32'(exp_frames));

    // reset mid-WAIT, then requester 0 must win first
    send(1, 8'h77);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    exp_frames = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    req_data[7:0]   = 8'h21;
    req_data[23:16] = 8'h23;
    exp_q.push_back(8'h21); gid_q.push_back(2'd0);
    exp_q.push_back(8'h23); gid_q.push_back(2'd2);
    req_valid = 4'b0101;
    wait_ready(0);
    req_valid[0] = 1'b0;
    wait_ready(2);
    req_valid[2] = 1'b0;
    wait_idle();
    check("post_rst_frames", 32'(frame_cnt), 32'(exp_frames));
`else
    // spurious done in IDLE
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    check("spur_state", 32'(state_dbg), 32'(IDLE));
    check("spur_frames", 32'(frame_cnt), 32'd0);

    // watchdog: transmitter never answers
    model_en = 1'b0;
    send(3, 8'h3C);
    t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (err_timeout) seen = 1'b1;
    end
    check("to_seen", 32'(seen), 32'd1);
    check("to_delay", 32'(cyc - t0), 32'd6);
    check("to_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    check("to_pulse_width", 32'(err_timeout), 32'd0);
    check("to_frames", 32'(frame_cnt), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
`endif

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
